// File: rtl/get_clk_div.sv
// get_clk_div: multi-channel fabric clock divider.
// Produces NUM_CH divided clocks plus one-cycle enables from clk_in. Each
// channel has a runtime-programmable ratio that is swapped in only at that
// channel's period boundary (or on sync_in), so no partial period is emitted.
// Optional build macro: GET_CLK_DIV_PHASE_EN adds a per-channel start phase
// used on apply and on sync_in. Without it cfg_phase is ignored.
//
// Config handshake: a transfer happens on any cycle with cfg_valid & cfg_ready.
// cfg_ready is combinational on cfg_ch (low while that channel still holds an
// unapplied update, always high for out-of-range indices); cfg_valid may be
// held high while cfg_ready is low and the payload must stay stable meanwhile.
module get_clk_div #(
   parameter int NUM_CH   = 4,
   parameter int DIV_W    = 16,
   parameter int DEF_DIV  = 10,
   parameter int LOCK_CYC = 4
) (
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              sync_in,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [2:0]        cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_phase,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);

   // Period counter only needs to reach LOCK_CYC, then it saturates.
   localparam int PW = (LOCK_CYC < 1) ? 1 : $clog2(LOCK_CYC + 1);
   localparam logic [PW-1:0]    LOCK_MAX  = PW'(LOCK_CYC);
   localparam logic [PW-1:0]    PER_ONE   = PW'(1);
   localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

   // Ratios below 2 cannot make a clock; they are stored raw and clamped here.
   function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
      return (d < TWO) ? TWO : d;
   endfunction

   // Per-channel state.
   logic [DIV_W-1:0]  cnt_q     [NUM_CH];
   logic [DIV_W-1:0]  cnt_d     [NUM_CH];
   logic [DIV_W-1:0]  div_q     [NUM_CH];
   logic [DIV_W-1:0]  div_d     [NUM_CH];
   logic [DIV_W-1:0]  shd_div_q [NUM_CH];
   logic [DIV_W-1:0]  shd_div_d [NUM_CH];
   logic [PW-1:0]     per_q     [NUM_CH];
   logic [PW-1:0]     per_d     [NUM_CH];
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] clk_q, clk_d;
   logic [NUM_CH-1:0] ce_q, ce_d;
   logic              locked_q, locked_d;
   logic              cfg_err_q, cfg_err_d;

`ifdef GET_CLK_DIV_PHASE_EN
   logic [DIV_W-1:0]  phase_q     [NUM_CH];
   logic [DIV_W-1:0]  phase_d     [NUM_CH];
   logic [DIV_W-1:0]  shd_phase_q [NUM_CH];
   logic [DIV_W-1:0]  shd_phase_d [NUM_CH];
`else
   logic              unused_cfg_phase;
   assign unused_cfg_phase = ^cfg_phase;
`endif

   // Per-channel decode.
   logic [DIV_W-1:0]  eff_div    [NUM_CH];
   logic [DIV_W-1:0]  new_phase  [NUM_CH];
   logic [DIV_W-1:0]  sync_start [NUM_CH];
   logic [NUM_CH-1:0] wrap;
   logic [NUM_CH-1:0] apply;
   logic [NUM_CH-1:0] wr_sel;

   // Config port decode.
   logic       ch_in_range;
   logic [7:0] pend_ext;
   logic       xfer;
   logic       xfer_ok;

   assign ch_in_range = (32'(cfg_ch) < 32'(NUM_CH));
   assign pend_ext    = 8'(pend_q);
   assign cfg_ready   = ch_in_range ? ~pend_ext[cfg_ch] : 1'b1;
   assign xfer        = cfg_valid & cfg_ready;
   assign xfer_ok     = xfer & ch_in_range;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign eff_div[g] = clamp_div(div_q[g]);
      // >= rather than == so a counter can never run away past the ratio.
      assign wrap[g]    = (cnt_q[g] >= (eff_div[g] - ONE));
      assign apply[g]   = pend_q[g] & (wrap[g] | sync_in);
      assign wr_sel[g]  = xfer_ok & (cfg_ch == 3'(g));
`ifdef GET_CLK_DIV_PHASE_EN
      // A phase outside the new period would skip the wrap; start at 0 instead.
      assign new_phase[g]  = (shd_phase_q[g] < clamp_div(shd_div_q[g])) ?
                             shd_phase_q[g] : '0;
      assign sync_start[g] = phase_q[g];
`else
      assign new_phase[g]  = '0;
      assign sync_start[g] = '0;
`endif
   end

   // Next-state for every channel: counter, ratio swap, shadow write, period count.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i]     = cnt_q[i];
         div_d[i]     = div_q[i];
         shd_div_d[i] = shd_div_q[i];
         per_d[i]     = per_q[i];
         pend_d[i]    = pend_q[i];
`ifdef GET_CLK_DIV_PHASE_EN
         phase_d[i]     = phase_q[i];
         shd_phase_d[i] = shd_phase_q[i];
`endif
         // Outputs are a registered view of the current count.
         clk_d[i] = (cnt_q[i] < (eff_div[i] >> 1));
         ce_d[i]  = wrap[i];

         if (apply[i]) begin
            // Swap in the shadow ratio; the first new period starts next cycle.
            div_d[i]  = shd_div_q[i];
            cnt_d[i]  = new_phase[i];
            pend_d[i] = 1'b0;
            per_d[i]  = '0;
`ifdef GET_CLK_DIV_PHASE_EN
            phase_d[i] = new_phase[i];
`endif
         end else if (sync_in) begin
            // Sync beats a coincident wrap: the start value loads exactly once.
            cnt_d[i] = sync_start[i];
            per_d[i] = '0;
         end else if (wrap[i]) begin
            cnt_d[i] = '0;
            if (per_q[i] < LOCK_MAX) begin
               per_d[i] = per_q[i] + PER_ONE;
            end
         end else begin
            cnt_d[i] = cnt_q[i] + ONE;
         end

         // Never coincides with apply: cfg_ready is low while pending is set.
         if (wr_sel[i]) begin
            shd_div_d[i] = cfg_div;
            pend_d[i]    = 1'b1;
`ifdef GET_CLK_DIV_PHASE_EN
            shd_phase_d[i] = cfg_phase;
`endif
         end
      end
   end

   // Lock is computed from next-state so a new write drops it on the next cycle.
   always_comb begin
      locked_d  = ~(|pend_d);
      for (int i = 0; i < NUM_CH; i++) begin
         if (per_d[i] < LOCK_MAX) begin
            locked_d = 1'b0;
         end
      end
      cfg_err_d = xfer & ~ch_in_range;
   end

   // State registers; asynchronous reset discards any pending update.
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]     <= '0;
            div_q[i]     <= DEF_DIV_V;
            shd_div_q[i] <= DEF_DIV_V;
            per_q[i]     <= '0;
`ifdef GET_CLK_DIV_PHASE_EN
            phase_q[i]     <= '0;
            shd_phase_q[i] <= '0;
`endif
         end
         pend_q    <= '0;
         clk_q     <= '0;
         ce_q      <= '0;
         locked_q  <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i]     <= cnt_d[i];
            div_q[i]     <= div_d[i];
            shd_div_q[i] <= shd_div_d[i];
            per_q[i]     <= per_d[i];
`ifdef GET_CLK_DIV_PHASE_EN
            phase_q[i]     <= phase_d[i];
            shd_phase_q[i] <= shd_phase_d[i];
`endif
         end
         pend_q    <= pend_d;
         clk_q     <= clk_d;
         ce_q      <= ce_d;
         locked_q  <= locked_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign clk_out = clk_q;
   assign ce_out  = ce_q;
   assign locked  = locked_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: doc/get_clk_div.md
Name: get_clk_div

Overview:
- Parametrised multi-channel fabric clock divider. It produces NUM_CH divided clocks and matching clock-enable pulses from one input clock.
- Every channel has its own divide ratio, which can be reprogrammed at runtime. A new ratio takes effect glitch-free at that channel's period boundary.
- Sits beside the MMCM/PLL wrappers. It covers low-rate clocks (sensor, UART, LED, slow peripheral) that cannot justify a dedicated MMCM output. It exports a `locked` status in the same style as those wrappers.

Parameters:
- NUM_CH, 4, number of output channels (1..8).
- DIV_W, 16, width of divide-ratio and counter fields.
- DEF_DIV, 10, divide ratio loaded into every channel at reset (must be >= 2).
- LOCK_CYC, 4, number of full periods every channel must complete before `locked` asserts.

Ports:
- clk_in  in  1  sole clock; all logic is on its rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- sync_in  in  1  one-cycle pulse; realigns all channel counters.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config accept; transfer happens when cfg_valid & cfg_ready.
- cfg_ch  in  3  target channel index.
- cfg_div  in  DIV_W  new divide ratio D.
- cfg_phase  in  DIV_W  start count after update or sync (used only with the option).
- cfg_err  out  1  one-cycle pulse when a transfer targets cfg_ch >= NUM_CH.
- clk_out  out  NUM_CH  divided clocks, registered.
- ce_out  out  NUM_CH  one-cycle enable per period, registered.
- locked  out  1  all channels stable.

Behaviour:
- Reset (reset_n=0), asynchronous:
  - Per channel: cnt=0, div=DEF_DIV, no pending update, period count=0.
  - Outputs: clk_out=0, ce_out=0, locked=0, cfg_err=0.
- Ratio clamp: an effective D < 2 is treated as 2. D is stored as written and clamped on use.
- Per-channel counter:
  - cnt counts 0..D-1, then wraps to 0.
  - The wrap cycle is the cycle where cnt==D-1.
- Output timing: outputs are registered from the current cnt, so they lag cnt by 1 cycle.
  - clk_out[i] = 1 while cnt < D>>1, else 0.
  - Even D gives 50% duty. Odd D gives high for floor(D/2) cycles and low for ceil(D/2).
  - ce_out[i] = 1 for the single cycle following cnt==D-1.
- Config acceptance:
  - cfg_ready = ~pending[cfg_ch]. It is combinational on cfg_ch, and is 1 for out-of-range indices.
  - An accepted transfer writes the shadow registers (div, phase) and sets pending[cfg_ch].
  - Out-of-range cfg_ch: the transfer is dropped and cfg_err pulses the next cycle.
- Config apply:
  - On the channel's wrap cycle with pending set: div takes the shadow value, cnt takes the start value, pending clears.
  - The first full period at the new ratio begins the following cycle. A partial period is never emitted.
- Start value: 0, or the phase value when the optional feature is compiled in.
- sync_in=1: all channels load the start value next cycle. Any pending update is applied at the same moment.
- Simultaneous events:
  - Config transfer in the same cycle as that channel's apply: the apply uses the old shadow. The new transfer is not accepted because cfg_ready=0.
  - sync_in in the same cycle as a wrap: sync wins, and the start value loads once.
- Locking:
  - Each channel has a saturating period counter that increments on each wrap.
  - The period counter clears on an apply of that channel, and clears on sync_in.
  - locked=1 when every channel's period counter >= LOCK_CYC and no channel has pending set. It is registered.
  - An accepted transfer to a valid channel drops locked on the next cycle.
- Reset mid-operation: all state returns to reset values immediately. Pending updates are discarded.

Optional Feature:
- Macro: GET_CLK_DIV_PHASE_EN.
- Defined:
  - cfg_phase is latched into the shadow on transfer. It is used as the start count on apply and on sync_in.
  - cfg_phase >= effective D is replaced by 0.
  - Reset phase is 0.
- Undefined:
  - cfg_phase is ignored and no phase registers are built.
  - The start value is always 0.

Test Plan:
- Reset release, NUM_CH=4, DEF_DIV=10, LOCK_CYC=4:
  - All clk_out have period 10, high 5 cycles.
  - ce_out pulses every 10 cycles.
  - locked rises 1 cycle after the 4th wrap, i.e. within 41 cycles of reset release.
- Write ch1 cfg_div=7 mid-period:
  - ch1 finishes its current 10-cycle period, then runs period 7 with high 3 and low 4.
  - locked drops the cycle after the transfer and reasserts after 4 periods of 7.
  - Other channels are undisturbed.
- Two back-to-back writes to ch2:
  - cfg_ready=0 for ch2 until its wrap.
  - The second write stalls, then applies at the following wrap.
  - A write to ch0 in the same cycle is accepted.
- cfg_ch=5 with NUM_CH=4:
  - Transfer accepted, cfg_err pulses once, no channel changes, locked unaffected.
- cfg_div=0 and cfg_div=1: channel runs at D=2, toggling every cycle.
- With GET_CLK_DIV_PHASE_EN: ch0 D=8 phase 0, ch1 D=8 phase 4, then pulse sync_in:
  - ch1 clk_out is exactly the inverse of ch0.
  - cfg_phase=9 with D=8 starts from 0.
- Assert reset_n=0 while a ch3 update is pending: after release, ch3 runs DEF_DIV and locked=0.
